// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared types, default LFSR taps and challenge-advance function for the PUF challenge driver
//
// Contents:
//   puf_state_e  - FSM state encoding used by puf_challenge_driver
//   TAPS_128     - default feedback mask for x^128 + x^126 + x^101 + x^99 + 1
//   lfsr_next    - one Fibonacci shift-left step for any width up to 128 bits
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_DONE   = 3'd5
    } puf_state_e;

    // Polynomial term x^k maps to tap bit k-1 because the feedback bit enters at bit 0
    // and the register shifts towards the MSB.
    localparam logic [127:0] TAPS_128 = (128'd1 << 127) | (128'd1 << 125)
                                      | (128'd1 << 100) | (128'd1 << 98);

    // Narrower challenges are zero-extended on entry; the result is masked back
    // to 'width' bits so the caller can simply truncate it.
    function automatic logic [127:0] lfsr_next(input logic [127:0] challenge,
                                               input logic [127:0] taps,
                                               input int unsigned  width);
        logic [127:0] mask;
        mask = (width >= 128) ? '1 : ((128'd1 << width) - 128'd1);
        return {challenge[126:0], ^(challenge & taps)} & mask;
    endfunction

endpackage

// File: rtl/puf_lfsr.sv
// rtl/puf_lfsr.sv - challenge register: seed load with zero guard and LFSR advance
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset (challenge returns to SEED)
//   load, seed  - load a new seed; a zero seed is replaced by 1 so the LFSR cannot lock up
//   advance     - step the LFSR once
//   challenge   - current challenge value
module puf_lfsr
    import puf_pkg::*;
#(
    parameter int           N    = 128,
    parameter logic [N-1:0] TAPS = TAPS_128[N-1:0],
    parameter logic [N-1:0] SEED = N'(1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] seed,
    input  logic         advance,
    output logic [N-1:0] challenge
);

    always_ff @(posedge clk) begin
        if (reset) begin
            challenge <= SEED;
        end else if (load) begin
            challenge <= (seed == '0) ? N'(1) : seed;
        end else if (advance) begin
            challenge <= N'(lfsr_next(128'(challenge), 128'(TAPS), N));
        end
    end

endmodule

// File: rtl/puf_challenge_driver.sv
// rtl/puf_challenge_driver.sv - arbiter-PUF initiator: challenge sequencing, launch/sample timing, response packing
//
// Optional feature macro: PUF_MAJORITY_VOTE_EN (each challenge evaluated three times,
// majority bit packed). Default build evaluates each challenge once.
//
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   start                  - request one response word (IDLE only)
//   seed_load, seed        - load challenge seed (IDLE only, wins over start)
//   puf_sel                - challenge onto the arbiter chain select bus
//   puf_in                 - launch edge into the chain
//   puf_reset              - clears the arbiter output latch
//   puf_out                - arbiter response bit
//   resp_data, resp_valid,
//   resp_ready             - packed response word handshake, first sample at MSB
//   busy                   - high whenever not IDLE
module puf_challenge_driver
    import puf_pkg::*;
#(
    parameter int           N             = 128,
    parameter int           RESP_BITS     = 32,
    parameter int           SETTLE_CYCLES = 8,
    parameter logic [N-1:0] TAPS          = TAPS_128[N-1:0],
    parameter logic [N-1:0] SEED          = N'(1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 seed_load,
    input  logic [N-1:0]         seed,
    output logic [N-1:0]         puf_sel,
    output logic                 puf_in,
    output logic                 puf_reset,
    input  logic                 puf_out,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 busy
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_CLEAR  = ST_CLEAR;
    localparam logic [2:0] S_LAUNCH = ST_LAUNCH;
    localparam logic [2:0] S_SETTLE = ST_SETTLE;
    localparam logic [2:0] S_SAMPLE = ST_SAMPLE;
    localparam logic [2:0] S_DONE   = ST_DONE;

    localparam int BW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [BW-1:0] LAST_BIT    = BW'(RESP_BITS - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    logic [2:0]    state;
    logic [BW-1:0] bit_cnt;
    logic [SW-1:0] settle_cnt;
    logic          bit_done;    // this SAMPLE finishes a response bit
    logic          sample_bit;  // bit shifted into resp_data when bit_done

    // Challenge only moves on the edge that leaves a bit-completing SAMPLE, so
    // puf_sel is stable for every evaluation of the same challenge.
    puf_lfsr #(
        .N    (N),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .load      ((state == S_IDLE) && seed_load),
        .seed      (seed),
        .advance   ((state == S_SAMPLE) && bit_done),
        .challenge (puf_sel)
    );

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] eval_cnt;
    logic [1:0] ones_cnt;
    logic [1:0] ones_sum;

    // At most two ones are held before the third sample, so the sum fits in 2 bits
    // and ones>=2 reduces to its MSB.
    assign ones_sum   = ones_cnt + {1'b0, puf_out};
    assign bit_done   = (eval_cnt == 2'd2);
    assign sample_bit = ones_sum[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            eval_cnt <= '0;
            ones_cnt <= '0;
        end else if (state == S_SAMPLE) begin
            if (bit_done) begin
                eval_cnt <= '0;
                ones_cnt <= '0;
            end else begin
                eval_cnt <= eval_cnt + 2'd1;
                ones_cnt <= ones_sum;
            end
        end
    end
`else
    assign bit_done   = 1'b1;
    assign sample_bit = puf_out;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            settle_cnt <= '0;
            resp_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!seed_load && start) begin
                        state   <= S_CLEAR;
                        bit_cnt <= '0;
                    end
                end
                S_CLEAR: begin
                    state <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    settle_cnt <= SETTLE_LOAD;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (bit_done) begin
                        resp_data <= RESP_BITS'({resp_data, sample_bit});
                        if (bit_cnt == LAST_BIT) begin
                            state <= S_DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= S_CLEAR;
                        end
                    end else begin
                        state <= S_CLEAR;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The latch is held clear whenever no evaluation is in flight; SAMPLE keeps it
    // released so the arbiter decision is still visible when it is captured.
    assign puf_in     = (state == S_LAUNCH) || (state == S_SETTLE);
    assign puf_reset  = (state == S_IDLE) || (state == S_CLEAR) || (state == S_DONE);
    assign resp_valid = (state == S_DONE);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_puf_challenge_driver.sv
// tb/tb_puf_challenge_driver.sv - self-checking scoreboard bench for puf_challenge_driver
module tb_puf_challenge_driver;

    localparam int        N    = 8;
    localparam int        RB   = 4;
    localparam int        SC   = 2;
    localparam logic [7:0] TAPS = 8'hB8;
    localparam logic [7:0] SEED = 8'h01;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int NEVAL = 3;
`else
    localparam int NEVAL = 1;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic          seed_load;
    logic [N-1:0]  seed;
    logic [N-1:0]  puf_sel;
    logic          puf_in;
    logic          puf_reset;
    logic          puf_out;
    logic [RB-1:0] resp_data;
    logic          resp_valid;
    logic          resp_ready;
    logic          busy;

    puf_challenge_driver #(
        .N             (N),
        .RESP_BITS     (RB),
        .SETTLE_CYCLES (SC),
        .TAPS          (TAPS),
        .SEED          (SEED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .seed_load  (seed_load),
        .seed       (seed),
        .puf_sel    (puf_sel),
        .puf_in     (puf_in),
        .puf_reset  (puf_reset),
        .puf_out    (puf_out),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_checks;
    int            n_errors;
    int            mode;
    int            hi_cnt;
    int            eval_idx;
    int            bit_idx;
    logic [7:0]    model_sel;
    logic          prev_in;
    logic          prev_rst;
    logic [RB-1:0] sb[$];
    logic [RB-1:0] held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_next(input logic [7:0] c);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (TAPS[i]) fb = fb ^ c[i];
        end
        return {c[6:0], fb};
    endfunction

    // mode 0: puf_out tied 1; mode 1: puf_out = challenge bit 0;
    // mode 2: votes 1,0,1 on even bits and 0,0,1 on odd bits
    function automatic logic [RB-1:0] expect_word(input logic [7:0] c0, input int m);
        logic [RB-1:0] w;
        logic [7:0]    c;
        logic          b;
        w = '0;
        c = c0;
        for (int i = 0; i < RB; i++) begin
            if (m == 0)      b = 1'b1;
            else if (m == 1) b = c[0];
            else             b = ((i % 2) == 0);
            w = {w[RB-2:0], b};
            c = model_next(c);
        end
        return w;
    endfunction

    // Advance one clock, then check launch framing and drive puf_out for a SAMPLE cycle.
    task automatic step();
        @(posedge clk);
        #1;
        if (puf_in && !prev_in) begin
            check("clear_before_launch", 32'(prev_rst), 32'd1);
            check("sel_at_launch", 32'(puf_sel), 32'(model_sel));
        end
        if (puf_in) hi_cnt++;
        puf_out = (mode == 0);
        if (!puf_in && !puf_reset) begin
            check("sel_at_sample", 32'(puf_sel), 32'(model_sel));
            check("puf_in_high_cycles", 32'(hi_cnt), 32'(SC + 1));
            hi_cnt = 0;
            if (mode == 1) puf_out = model_sel[0];
            else if (mode == 2) puf_out = ((bit_idx % 2) == 0) ? (eval_idx != 1) : (eval_idx == 2);
            eval_idx++;
            if (eval_idx == NEVAL) begin
                eval_idx  = 0;
                bit_idx++;
                model_sel = model_next(model_sel);
            end
        end
        prev_in  = puf_in;
        prev_rst = puf_reset;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset     = 1'b0;
        hi_cnt    = 0;
        eval_idx  = 0;
        bit_idx   = 0;
        model_sel = SEED;
    endtask

    task automatic run_word(input int m, input int hold, input bit poke);
        int cnt;
        mode     = m;
        bit_idx  = 0;
        eval_idx = 0;
        sb.push_back(expect_word(model_sel, m));
        start = 1'b1;
        step();
        start = 1'b0;
        cnt   = 0;
        while (!resp_valid && cnt < 2000) begin
            if (poke && cnt == 1) begin
                seed      = 8'h5A;
                seed_load = 1'b1;
                step();
                seed_load = 1'b0;
                cnt++;
                check("seed_ignored_busy", 32'(puf_sel), 32'(model_sel));
            end else begin
                step();
                cnt++;
            end
        end
        check("resp_valid_seen", 32'(resp_valid), 32'd1);
        check("latency", 32'(cnt), 32'(RB * (SC + 3) * NEVAL));
        held = sb.pop_front();
        check("resp_data", 32'(resp_data), 32'(held));
        for (int i = 0; i < hold; i++) begin
            start = (i == 4);
            step();
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_data", 32'(resp_data), 32'(held));
        end
        start      = 1'b1;
        resp_ready = 1'b1;
        step();
        start      = 1'b0;
        resp_ready = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd0);
        check("valid_after_accept", 32'(resp_valid), 32'd0);
        step();
        check("start_in_done_ignored", 32'(busy), 32'd0);
    endtask

    initial begin
        int guard;
        n_checks   = 0;
        n_errors   = 0;
        mode       = 0;
        hi_cnt     = 0;
        eval_idx   = 0;
        bit_idx    = 0;
        prev_in    = 1'b0;
        prev_rst   = 1'b1;
        model_sel  = SEED;
        start      = 1'b0;
        seed_load  = 1'b0;
        seed       = '0;
        puf_out    = 1'b0;
        resp_ready = 1'b0;
        reset      = 1'b1;
        step();
        do_reset();

        check("rst_puf_sel", 32'(puf_sel), 32'(SEED));
        check("rst_puf_in", 32'(puf_in), 32'd0);
        check("rst_puf_reset", 32'(puf_reset), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        run_word(0, 10, 1'b0);
        check("sel_after_word", 32'(puf_sel), 32'(model_sel));

        seed      = 8'h00;
        seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        model_sel = 8'h01;
        check("zero_seed_guard", 32'(puf_sel), 32'h01);

        run_word(1, 0, 1'b1);

        seed      = 8'h5A;
        seed_load = 1'b1;
        start     = 1'b1;
        step();
        seed_load = 1'b0;
        start     = 1'b0;
        model_sel = 8'h5A;
        check("seed_load_idle", 32'(puf_sel), 32'h5A);
        check("seed_beats_start", 32'(busy), 32'd0);

        run_word(1, 2, 1'b0);

        // reset during SETTLE of the third bit
        mode     = 0;
        bit_idx  = 0;
        eval_idx = 0;
        start    = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (bit_idx < 2 && guard < 500) begin
            step();
            guard++;
        end
        check("reached_bit2", 32'(bit_idx), 32'd2);
        for (int i = 0; i < 3; i++) step();
        check("in_settle", 32'(puf_in), 32'd1);
        do_reset();
        check("midrst_puf_sel", 32'(puf_sel), 32'(SEED));
        check("midrst_resp_data", 32'(resp_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_puf_reset", 32'(puf_reset), 32'd1);
        check("midrst_puf_in", 32'(puf_in), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);

`ifdef PUF_MAJORITY_VOTE_EN
        run_word(2, 0, 1'b0);
`endif
        run_word(1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
